// File: rtl/uart_tx_arbiter_if.sv
// Signal bundle between two requesters, the arbiter and the UART transmitter.
// Latency: none (wires only).
// Backpressure: none; requesters hold req until they see their gnt pulse.
interface uart_tx_arbiter_if;
  logic        req0;
  logic        req1;
  logic [6:0]  data0;
  logic [6:0]  data1;
  logic        gnt0;
  logic        gnt1;
  logic        tx_start;
  logic [6:0]  datain_tx;
  logic        busy;
  logic        owner;
  logic [15:0] frames_sent;

  // Requester / transmitter side.
  modport master (
    output req0, req1, data0, data1,
    input  gnt0, gnt1, tx_start, datain_tx, busy, owner, frames_sent
  );

  // Arbiter side.
  modport slave (
    input  req0, req1, data0, data1,
    output gnt0, gnt1, tx_start, datain_tx, busy, owner, frames_sent
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter granting one of two requesters a full UART frame slot,
// latency: grant, tx_start and payload are registered on the edge the request is sampled.
// Backpressure: requests are ignored in SEND/GAP; a request still high on return to IDLE is re-arbitrated.
// Optional macro UART_ARB_FRAME_CNT_EN builds a saturating completed-frame counter.
module uart_tx_arbiter #(
  parameter int CLKS_PER_BIT = 521,
  parameter int FRAME_BITS   = 10
) (
  input  logic                clk,
  input  logic                rst,
  uart_tx_arbiter_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  // Terminal counts for the frame and the stop-bit guard interval.
  localparam logic [15:0] SEND_LAST = 16'(CLKS_PER_BIT * FRAME_BITS - 1);
  localparam logic [15:0] GAP_LAST  = 16'(CLKS_PER_BIT - 1);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        tx_q, tx_d;
  logic        gnt0_q, gnt0_d;
  logic        gnt1_q, gnt1_d;
  logic [6:0]  dat_q, dat_d;
  logic        owner_q, owner_d;
  logic        prio_q, prio_d;   // requester favoured when both request
  logic        win;

  // Pick the winner: a lone request wins, a tie goes to the favoured requester.
  always_comb begin
    win = bus.req1 && (!bus.req0 || prio_q);
  end

  // Next-state and next-output logic; every target holds unless changed below.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tx_d    = tx_q;
    gnt0_d  = 1'b0;
    gnt1_d  = 1'b0;
    dat_d   = dat_q;
    owner_d = owner_q;
    prio_d  = prio_q;
    case (state_q)
      IDLE: begin
        tx_d = 1'b0;
        if (bus.req0 || bus.req1) begin
          state_d = SEND;
          tx_d    = 1'b1;
          gnt0_d  = !win;
          gnt1_d  = win;
          dat_d   = win ? bus.data1 : bus.data0;
          owner_d = win;
          prio_d  = !win;
          cnt_d   = '0;
        end
      end
      SEND: begin
        if (cnt_q == SEND_LAST) begin
          state_d = GAP;
          tx_d    = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  // State and registered outputs; reset aborts any frame in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tx_q    <= 1'b0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      dat_q   <= '0;
      owner_q <= 1'b0;
      prio_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tx_q    <= tx_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      dat_q   <= dat_d;
      owner_q <= owner_d;
      prio_q  <= prio_d;
    end
  end

  assign bus.gnt0      = gnt0_q;
  assign bus.gnt1      = gnt1_q;
  assign bus.tx_start  = tx_q;
  assign bus.datain_tx = dat_q;
  assign bus.owner     = owner_q;
  assign bus.busy      = (state_q != IDLE);

`ifdef UART_ARB_FRAME_CNT_EN
  logic [15:0] frames_q;
  logic        frame_done;

  assign frame_done = (state_q == SEND) && (cnt_q == SEND_LAST);

  // Count frames that reach the SEND->GAP transition, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      frames_q <= '0;
    end else if (frame_done && (frames_q != 16'hFFFF)) begin
      frames_q <= frames_q + 16'd1;
    end
  end

  assign bus.frames_sent = frames_q;
`else
  assign bus.frames_sent = '0;
`endif

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk (rising edge) and rst; all state updates on rising clk, rst sampled only on rising clk.
REQ-002 Parameter CLKS_PER_BIT, default 521: clk cycles per UART bit (10 MHz clk, 19200 baud).
REQ-003 Parameter FRAME_BITS, default 10: bit slots per frame (start + 7 data + parity + stop).
REQ-004 clk  input  1  system clock.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 req0 / req1  input  1 each  level request from requester 0 / 1.
REQ-007 data0 / data1  input  7 each  payload offered by requester 0 / 1.
REQ-008 gnt0 / gnt1  output  1 each  one-cycle accept pulse; payload latched.
REQ-009 tx_start  output  1  level start to UART transmitter, high for the whole frame.
REQ-010 datain_tx  output  7  payload to UART transmitter.
REQ-011 busy  output  1  high in any state other than IDLE.
REQ-012 owner  output  1  index of the requester owning the current or last frame.
REQ-013 frames_sent  output  16  completed-frame count (see Configuration).

Function
REQ-014 FSM states SHALL be IDLE, SEND and GAP; no other reachable states.
REQ-015 IDLE: no request -> stay; outputs hold, tx_start=0.
REQ-016 IDLE with a request sampled at edge N -> at edge N: state=SEND, tx_start=1, winner's gnt=1, datain_tx=winner's data, owner=winner index, counter=0.
REQ-017 gnt SHALL be high for exactly one cycle per accepted frame; gnt0 and gnt1 never high together.
REQ-018 Arbitration: single request wins; both high -> requester not granted last wins (round-robin); after reset requester 0 has priority.
REQ-019 SEND: tx_start stays high for exactly CLKS_PER_BIT*FRAME_BITS cycles, then state=GAP, tx_start=0, counter=0.
REQ-020 GAP: tx_start stays low for exactly CLKS_PER_BIT cycles (stop-bit guard), then state=IDLE.
REQ-021 Back-to-back frames: tx_start low for exactly CLKS_PER_BIT+1 cycles between frames (GAP plus one IDLE cycle).
REQ-022 datain_tx and owner SHALL stay stable from grant until the next grant; data0/data1 changes after grant are ignored.
REQ-023 Requests in SEND or GAP are not granted; a request still high on return to IDLE is a new request.
REQ-024 Frame timing counter: 16 bits, unsigned; CLKS_PER_BIT*FRAME_BITS SHALL be <= 65535, otherwise behaviour is undefined.
REQ-025 busy SHALL be combinationally equal to (state != IDLE).

Reset
REQ-026 rst high at an edge: state=IDLE, tx_start=0, gnt0=gnt1=0, datain_tx=0, owner=0, counter=0, round-robin pointer=requester 0, frames_sent=0.
REQ-027 rst during SEND or GAP SHALL abort the frame: tx_start low on the following cycle, with no frames_sent increment.
REQ-028 rst has priority over every request and state transition in the same cycle.

Configuration
REQ-029 Macro UART_ARB_FRAME_CNT_EN defined: frames_sent increments by 1 at each SEND->GAP transition, saturating at 16'hFFFF.
REQ-030 Macro undefined: frames_sent is constant 0 and no counter register is built; all other behaviour is identical.

Verification (bench: CLKS_PER_BIT=4, FRAME_BITS=10)
REQ-031 Reset, then req0=1, data0=7'h55 -> 1 cycle later gnt0=1 for 1 cycle, tx_start=1 for 40 cycles, datain_tx=7'h55, owner=0, then busy=0 after 4 more cycles.
REQ-032 req0 and req1 held high together, data0=7'h7F, data1=7'h2A -> grants alternate gnt0, gnt1, gnt0, ...; datain_tx 7'h7F, 7'h2A, ...; tx_start low for exactly 5 cycles between frames.
REQ-033 data0 changed from 7'h55 to 7'h00 during SEND -> datain_tx remains 7'h55 until the next grant.
REQ-034 rst pulsed at cycle 20 of SEND -> next cycle tx_start=0, busy=0, owner=0; the next req1 is granted normally.
REQ-035 With UART_ARB_FRAME_CNT_EN defined, 3 frames complete -> frames_sent=3; without the macro -> frames_sent=0 throughout.
REQ-036 req1 pulsed high for 1 cycle during GAP only -> no gnt1, and state returns to IDLE.
